// File: rtl/zigbee_tx_pkg.sv
// zigbee_tx_pkg: shared scheduler state encoding and 802.15.4 PHY constants
package zigbee_tx_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_PHR,
    S_FETCH,
    S_PAYLOAD,
    S_FCS,
    S_DONE
  } tx_sched_state_t;
  localparam int PHY_MAX_PSDU = 127;
  localparam logic [7:0] SFD_DEFAULT = 8'hA7;
  localparam int FCS_LEN = 2;
endpackage

// File: rtl/crc16_802154.sv
// crc16_802154: LSB-first CRC-16/ITU-T (reflected poly 0x8408, init 0) byte accumulator with clear/enable
module crc16_802154 (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [15:0] o_crc_q,
  output logic [15:0] o_crc_d
);
  logic [15:0] r_crc;
  logic [15:0] w_nxt;
  always_comb begin
    w_nxt = r_crc ^ {8'h00, i_data};
    for (int i = 0; i < 8; i++) w_nxt = w_nxt[0] ? ((w_nxt >> 1) ^ 16'h8408) : (w_nxt >> 1);
    o_crc_d = i_clr ? 16'h0000 : i_en ? w_nxt : r_crc;
  end
  always_ff @(posedge clk) r_crc <= reset ? 16'h0000 : o_crc_d;
  assign o_crc_q = r_crc;
endmodule

// File: rtl/tx_frame_sched.sv
// tx_frame_sched: 802.15.4 PPDU byte sequencer (preamble, SFD, PHR, FIFO payload) over valid/ready.
// Define TX_FCS_EN to append a 2-byte CRC-16 FCS after the payload.
module tx_frame_sched
  import zigbee_tx_pkg::*;
#(
  parameter int         PREAMBLE_BYTES = 4,
  parameter logic [7:0] SFD_BYTE       = SFD_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] frame_len,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo_rd_data,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       busy,
  output logic       done,
  output logic       err_underflow,
  output logic       err_len
);
  tx_sched_state_t r_state, w_state, w_tail_state;
  logic [7:0] r_byte_out, w_byte_out, w_tail_byte;
  logic       r_byte_valid, w_byte_valid, w_tail_valid;
  logic [6:0] r_cnt, w_cnt, r_len, w_len, w_pay;
  logic       w_xfer, w_len_ok;
  assign w_xfer = r_byte_valid && byte_ready;
`ifdef TX_FCS_EN
  logic [15:0] w_crc_q, w_crc_d;
  crc16_802154 u_crc (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (r_state == S_IDLE),
    .i_en    (r_state == S_PAYLOAD && w_xfer),
    .i_data  (r_byte_out),
    .o_crc_q (w_crc_q),
    .o_crc_d (w_crc_d)
  );
  assign w_pay        = r_len - 7'(FCS_LEN);
  assign w_len_ok     = frame_len >= 7'(FCS_LEN);
  assign w_tail_state = S_FCS;
  assign w_tail_valid = 1'b1;
  assign w_tail_byte  = w_crc_d[7:0];
`else
  assign w_pay        = r_len;
  assign w_len_ok     = 1'b1;
  assign w_tail_state = S_DONE;
  assign w_tail_valid = 1'b0;
  assign w_tail_byte  = r_byte_out;
`endif
  always_comb begin
    w_state       = r_state;
    w_byte_out    = r_byte_out;
    w_byte_valid  = r_byte_valid;
    w_cnt         = r_cnt;
    w_len         = r_len;
    fifo_rd_en    = 1'b0;
    err_underflow = 1'b0;
    err_len       = 1'b0;
    done          = 1'b0;
    busy          = r_state != S_IDLE;
    case (r_state)
      S_IDLE: if (start) begin
        if (w_len_ok) begin
          w_state      = S_PREAMBLE;
          w_len        = frame_len;
          w_cnt        = 7'd0;
          w_byte_out   = 8'h00;
          w_byte_valid = 1'b1;
        end else err_len = 1'b1;
      end
      S_PREAMBLE: if (w_xfer) begin
        if (r_cnt == 7'(PREAMBLE_BYTES - 1)) begin
          w_state    = S_SFD;
          w_byte_out = SFD_BYTE;
          w_cnt      = 7'd0;
        end else w_cnt = r_cnt + 7'd1;
      end
      S_SFD: if (w_xfer) begin
        w_state    = S_PHR;
        w_byte_out = {1'b0, r_len};
      end
      S_PHR: if (w_xfer) begin
        if (w_pay == 7'd0) begin
          w_state      = w_tail_state;
          w_byte_out   = w_tail_byte;
          w_byte_valid = w_tail_valid;
          w_cnt        = 7'd1;
        end else begin
          w_state      = S_FETCH;
          w_byte_valid = 1'b0;
          w_cnt        = w_pay;
        end
      end
      S_FETCH: if (fifo_empty) begin
        err_underflow = 1'b1;
        w_state       = S_IDLE;
      end else begin
        fifo_rd_en = 1'b1;
        w_state    = S_PAYLOAD;
      end
      // first PAYLOAD cycle captures the popped byte; later cycles wait for the handshake
      S_PAYLOAD: if (!r_byte_valid) begin
        w_byte_out   = fifo_rd_data;
        w_byte_valid = 1'b1;
      end else if (byte_ready) begin
        if (r_cnt == 7'd1) begin
          w_state      = w_tail_state;
          w_byte_out   = w_tail_byte;
          w_byte_valid = w_tail_valid;
          w_cnt        = 7'd1;
        end else begin
          w_state      = S_FETCH;
          w_byte_valid = 1'b0;
          w_cnt        = r_cnt - 7'd1;
        end
      end
`ifdef TX_FCS_EN
      S_FCS: if (w_xfer) begin
        if (r_cnt == 7'd1) begin
          w_byte_out = w_crc_q[15:8];
          w_cnt      = 7'd0;
        end else begin
          w_state      = S_DONE;
          w_byte_valid = 1'b0;
        end
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_byte_out   <= 8'h00;
      r_byte_valid <= 1'b0;
      r_cnt        <= 7'd0;
      r_len        <= 7'd0;
    end else begin
      r_state      <= w_state;
      r_byte_out   <= w_byte_out;
      r_byte_valid <= w_byte_valid;
      r_cnt        <= w_cnt;
      r_len        <= w_len;
    end
  end
  assign byte_out   = r_byte_out;
  assign byte_valid = r_byte_valid;
endmodule

// File: tb/tb_tx_frame_sched.sv
// tb_tx_frame_sched: directed and randomized frames checked against a list-based PPDU reference model
module tb_tx_frame_sched;
`ifdef TX_FCS_EN
  localparam int FO = 2;
`else
  localparam int FO = 0;
`endif
  localparam int PB = 4;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, byte_ready = 1'b1;
  logic [6:0] frame_len = 7'd0;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_empty, fifo_rd_en, byte_valid, busy, done, err_underflow, err_len;
  logic [7:0] byte_out;
  logic [7:0] fifo_mem [256];
  logic [7:0] wr_ptr = 8'd0, rd_ptr = 8'd0;
  logic [7:0] got_q[$], pay[$];
  int n_tests = 0, n_fail = 0;
  int rd_cnt = 0, done_cnt = 0, uf_cnt = 0, len_cnt = 0;
  int mode = 0, ph = 0;
  always #5 clk = ~clk;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) if (fifo_rd_en) begin
    fifo_rd_data <= fifo_mem[rd_ptr];
    rd_ptr <= rd_ptr + 8'd1;
  end
  tx_frame_sched dut (
    .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .done(done), .err_underflow(err_underflow), .err_len(err_len)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  logic pv = 1'b0, pr = 1'b0, prs = 1'b1;
  logic [7:0] pb = 8'h00;
  always @(negedge clk) begin
    if (pv && !pr && !prs) chk("hold", {23'b0, byte_valid, byte_out}, {23'b0, 1'b1, pb});
    if (fifo_rd_en) chk("rd_when_empty", {31'b0, fifo_empty}, 32'd0);
    if (byte_valid && byte_ready && !reset) got_q.push_back(byte_out);
    rd_cnt   <= rd_cnt + int'(fifo_rd_en);
    done_cnt <= done_cnt + int'(done);
    uf_cnt   <= uf_cnt + int'(err_underflow);
    len_cnt  <= len_cnt + int'(err_len);
    pv  <= byte_valid;
    pr  <= byte_ready;
    prs <= reset;
    pb  <= byte_out;
  end
  task automatic tick();
    @(posedge clk);
    #1;
    ph++;
    byte_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (ph % 3 == 0) : 1'($urandom_range(0, 1));
  endtask
  function automatic logic [15:0] crc_ref(input logic [7:0] q[$]);
    logic [15:0] c = 16'h0000;
    foreach (q[k]) begin
      c ^= {8'h00, q[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction
  task automatic load_fifo();
    foreach (pay[k]) begin
      fifo_mem[wr_ptr] = pay[k];
      wr_ptr = wr_ptr + 8'd1;
    end
  endtask
  task automatic rand_pay(input int n);
    pay.delete();
    for (int k = 0; k < n; k++) pay.push_back(8'($urandom));
  endtask
  task automatic run_frame(input int len, input int m, input bit mid);
    int p, avail, nsend, g0, r0, d0, u0, l0, t;
    bit uf;
    logic [7:0] exp[$], sub[$];
    logic [15:0] c;
    p = len - FO;
    avail = pay.size();
    uf = avail < p;
    nsend = uf ? avail : p;
    mode = m;
    load_fifo();
    for (int k = 0; k < PB; k++) exp.push_back(8'h00);
    exp.push_back(8'hA7);
    exp.push_back(8'(len));
    for (int k = 0; k < nsend; k++) begin
      exp.push_back(pay[k]);
      sub.push_back(pay[k]);
    end
    if (FO > 0 && !uf) begin
      c = crc_ref(sub);
      exp.push_back(c[7:0]);
      exp.push_back(c[15:8]);
    end
    g0 = got_q.size(); r0 = rd_cnt; d0 = done_cnt; u0 = uf_cnt; l0 = len_cnt;
    frame_len = 7'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", {31'b0, busy}, 32'd1);
    chk("start_valid", {31'b0, byte_valid}, 32'd1);
    if (mid) begin
      repeat (2) tick();
      frame_len = 7'(len + 1);
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && uf_cnt == u0 && t < 3000) begin
      tick();
      t++;
    end
    chk("finish_in_budget", 32'(t < 3000), 32'd1);
    tick();
    chk("busy_after", {31'b0, busy}, 32'd0);
    chk("stream_len", got_q.size() - g0, exp.size());
    for (int k = 0; k < exp.size(); k++)
      chk("stream_byte", (g0 + k < got_q.size()) ? {24'b0, got_q[g0 + k]} : 32'h100, {24'b0, exp[k]});
    chk("rd_pulses", rd_cnt - r0, nsend);
    chk("done_pulses", done_cnt - d0, 32'(!uf));
    chk("uf_pulses", uf_cnt - u0, 32'(uf));
    chk("len_err_pulses", len_cnt - l0, 32'd0);
    wr_ptr = rd_ptr;
    pay.delete();
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk(tag, {24'b0, byte_out}, 32'h00);
    chk(tag, {25'b0, byte_valid, fifo_rd_en, busy, done, err_underflow, err_len, 1'b0}, 32'd0);
  endtask
  initial begin
    int t, d0, u0, l0, len;
    repeat (3) tick();
    chk_idle_outputs("reset_state");
    reset = 1'b0;
    tick();
    chk_idle_outputs("after_reset");
    pay = '{8'h11, 8'h22, 8'h33};
    run_frame(3 + FO, 0, 0);
    pay = '{8'h11, 8'h22, 8'h33};
    run_frame(3 + FO, 1, 0);
    rand_pay(2);
    run_frame(4 + FO, 0, 0);
    run_frame(FO, 0, 0);
`ifdef TX_FCS_EN
    pay = '{8'h01, 8'h02, 8'h03};
    run_frame(5, 0, 0);
    l0 = len_cnt;
    frame_len = 7'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fcs_short_busy", {31'b0, busy}, 32'd0);
    tick();
    chk("fcs_short_err_len", len_cnt - l0, 32'd1);
`endif
    rand_pay(5);
    run_frame(5 + FO, 2, 1);
    rand_pay(6);
    load_fifo();
    d0 = done_cnt; u0 = uf_cnt;
    frame_len = 7'(6 + FO);
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (!fifo_rd_en && t < 200) begin
      tick();
      t++;
    end
    chk("reach_payload", 32'(t < 200), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    chk_idle_outputs("mid_reset");
    reset = 1'b0;
    wr_ptr = rd_ptr;
    tick();
    chk("mid_reset_no_pulse", (done_cnt - d0) + (uf_cnt - u0), 32'd0);
    rand_pay(4);
    run_frame(4 + FO, 0, 0);
    rand_pay(127 - FO);
    run_frame(127, 0, 0);
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(FO, FO + 12);
      rand_pay(($urandom_range(0, 3) == 0) ? $urandom_range(0, len - FO) : len - FO + $urandom_range(0, 2));
      run_frame(len, $urandom_range(0, 2), 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
